asg_sweep: RTL and testbench

// Frequency-sweep sequencer for one ASG channel. Drives the ASG step-size input cfg_stp so the output frequency ramps

---
 rtl/asg_pkg.sv | 19 +
 rtl/asg_sweep_step.sv | 30 +++
 rtl/asg_sweep.sv | 185 ++++++++++++++++++
 tb/tb_asg_sweep.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asg_pkg.sv
// Shared types for the ASG frequency-sweep sequencer.
package asg_pkg;

  localparam int unsigned ASG_CW = 30;
  localparam int unsigned ASG_DW = 32;
  localparam int unsigned ASG_NW = 16;

  typedef enum logic [1:0] {
    SWP_SINGLE   = 2'd0,
    SWP_REPEAT   = 2'd1,
    SWP_PINGPONG = 2'd2
  } asg_swp_mod_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } asg_swp_st_t;

endpackage

// File: rtl/asg_sweep_step.sv
// One sweep step: cur +/- inc toward tgt, clamped at tgt using a guard bit so
// the result never wraps. reach flags that the step lands exactly on tgt.
module asg_sweep_step #(
  parameter int unsigned CW = 30
) (
  input  logic [CW-1:0] cur,
  input  logic [CW-1:0] tgt,
  input  logic [CW-1:0] inc,
  input  logic          dir,
  output logic [CW-1:0] nxt,
  output logic          reach
);

  logic [CW:0] sum;
  logic [CW:0] dif;

  always_comb begin
    sum   = {1'b0, cur} + {1'b0, inc};
    dif   = {1'b0, cur} - {1'b0, inc};
    nxt   = tgt;
    if (!dir) begin
      if (sum < {1'b0, tgt}) nxt = sum[CW-1:0];
    end else begin
      // dif[CW] set means the subtraction went below zero
      if (!dif[CW] && (dif > {1'b0, tgt})) nxt = dif[CW-1:0];
    end
    reach = (nxt == tgt);
  end

endmodule

// File: rtl/asg_sweep.sv
// Frequency-sweep sequencer: ramps the ASG step word from beg to end with a
// programmable dwell, in single, repeated or ping-pong mode.
module asg_sweep
  import asg_pkg::*;
#(
  parameter int unsigned CW = ASG_CW,
  parameter int unsigned DW = ASG_DW,
  parameter int unsigned NW = ASG_NW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctl_str,
  input  logic          ctl_stp,
  input  logic [1:0]    cfg_mod,
  input  logic [CW-1:0] cfg_beg,
  input  logic [CW-1:0] cfg_end,
  input  logic [CW-1:0] cfg_inc,
  input  logic [DW-1:0] cfg_dwl,
  input  logic [NW-1:0] cfg_rpt,
  input  logic          cfg_inf,
  output logic [CW-1:0] stp_o,
  output logic          stp_upd,
  output logic          sts_run,
  output logic [NW-1:0] sts_cnt,
  output logic          irq_end
);

  asg_swp_st_t  state_q, state_d;
  asg_swp_mod_t mod_q, mod_d;
  logic [CW-1:0] beg_q, beg_d, fin_q, fin_d, inc_q, inc_d;
  logic [DW-1:0] dwl_q, dwl_d, dwc_q, dwc_d;
  logic [NW-1:0] rpt_q, rpt_d, cnt_q, cnt_d;
  logic          inf_q, inf_d;
  logic [CW-1:0] stp_q, stp_d, tgt_q, tgt_d;
  logic          dir_q, dir_d, at_q, at_d;
  logic          upd_q, upd_d, irq_q, irq_d;

  logic [CW-1:0] tgt_swap;
  logic [CW-1:0] step_nxt, turn_nxt;
  logic          step_rch, turn_rch;

  assign tgt_swap = (tgt_q == fin_q) ? beg_q : fin_q;

  asg_sweep_step #(.CW(CW)) u_step (
    .cur   (stp_q),
    .tgt   (tgt_q),
    .inc   (inc_q),
    .dir   (dir_q),
    .nxt   (step_nxt),
    .reach (step_rch)
  );

  // Ping-pong turnaround: first step back toward the opposite endpoint.
  asg_sweep_step #(.CW(CW)) u_turn (
    .cur   (stp_q),
    .tgt   (tgt_swap),
    .inc   (inc_q),
    .dir   (~dir_q),
    .nxt   (turn_nxt),
    .reach (turn_rch)
  );

  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    beg_d   = beg_q;
    fin_d   = fin_q;
    inc_d   = inc_q;
    dwl_d   = dwl_q;
    rpt_d   = rpt_q;
    inf_d   = inf_q;
    stp_d   = stp_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    at_d    = at_q;
    dwc_d   = dwc_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    irq_d   = 1'b0;

    if (ctl_stp) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctl_str) begin
            case (cfg_mod)
              2'd1:    mod_d = SWP_REPEAT;
              2'd2:    mod_d = SWP_PINGPONG;
              default: mod_d = SWP_SINGLE;
            endcase
            beg_d   = cfg_beg;
            fin_d   = cfg_end;
            inc_d   = (cfg_inc == '0) ? CW'(1) : cfg_inc;
            dwl_d   = cfg_dwl;
            rpt_d   = cfg_rpt;
            inf_d   = cfg_inf;
            stp_d   = cfg_beg;
            tgt_d   = cfg_end;
            dir_d   = (cfg_end < cfg_beg);
            at_d    = (cfg_end == cfg_beg);
            dwc_d   = '0;
            cnt_d   = '0;
            upd_d   = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          dwc_d = dwc_q + DW'(1);
          if (dwc_q == dwl_q) begin
            dwc_d = '0;
            if (!at_q) begin
              stp_d = step_nxt;
              at_d  = step_rch;
              upd_d = 1'b1;
            end else if ((mod_q == SWP_SINGLE) || (!inf_q && (cnt_q == rpt_q))) begin
              state_d = ST_IDLE;
              irq_d   = 1'b1;
            end else begin
              upd_d = 1'b1;
              if (!inf_q) cnt_d = cnt_q + NW'(1);
              if (mod_q == SWP_PINGPONG) begin
                dir_d = ~dir_q;
                tgt_d = tgt_swap;
                stp_d = turn_nxt;
                at_d  = turn_rch;
              end else begin
                dir_d = (fin_q < beg_q);
                tgt_d = fin_q;
                stp_d = beg_q;
                at_d  = (fin_q == beg_q);
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mod_q   <= SWP_SINGLE;
      beg_q   <= '0;
      fin_q   <= '0;
      inc_q   <= '0;
      dwl_q   <= '0;
      rpt_q   <= '0;
      inf_q   <= 1'b0;
      stp_q   <= '0;
      tgt_q   <= '0;
      dir_q   <= 1'b0;
      at_q    <= 1'b0;
      dwc_q   <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      beg_q   <= beg_d;
      fin_q   <= fin_d;
      inc_q   <= inc_d;
      dwl_q   <= dwl_d;
      rpt_q   <= rpt_d;
      inf_q   <= inf_d;
      stp_q   <= stp_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      at_q    <= at_d;
      dwc_q   <= dwc_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
      irq_q   <= irq_d;
    end
  end

  assign stp_o   = stp_q;
  assign stp_upd = upd_q;
  assign sts_run = (state_q == ST_RUN);
  assign sts_cnt = cnt_q;
  assign irq_end = irq_q;

endmodule

// File: tb/tb_asg_sweep.sv
// Directed bench for asg_sweep: expected sequences are hand-derived per scenario.
module tb_asg_sweep;

  localparam int unsigned CW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 16;
  localparam logic [CW-1:0] MAXV = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ctl_str = 1'b0;
  logic          ctl_stp = 1'b0;
  logic [1:0]    cfg_mod = '0;
  logic [CW-1:0] cfg_beg = '0;
  logic [CW-1:0] cfg_end = '0;
  logic [CW-1:0] cfg_inc = '0;
  logic [DW-1:0] cfg_dwl = '0;
  logic [NW-1:0] cfg_rpt = '0;
  logic          cfg_inf = 1'b0;
  logic [CW-1:0] stp_o;
  logic          stp_upd;
  logic          sts_run;
  logic [NW-1:0] sts_cnt;
  logic          irq_end;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  asg_sweep #(.CW(CW), .DW(DW), .NW(NW)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctl_str (ctl_str),
    .ctl_stp (ctl_stp),
    .cfg_mod (cfg_mod),
    .cfg_beg (cfg_beg),
    .cfg_end (cfg_end),
    .cfg_inc (cfg_inc),
    .cfg_dwl (cfg_dwl),
    .cfg_rpt (cfg_rpt),
    .cfg_inf (cfg_inf),
    .stp_o   (stp_o),
    .stp_upd (stp_upd),
    .sts_run (sts_run),
    .sts_cnt (sts_cnt),
    .irq_end (irq_end)
  );

  // Returns on the negedge showing the first cycle of the sweep.
  task automatic start(input logic [1:0] mod, input logic [CW-1:0] beg, input logic [CW-1:0] fin,
                       input logic [CW-1:0] inc, input logic [DW-1:0] dwl,
                       input logic [NW-1:0] rpt, input logic inf);
    @(negedge clk);
    cfg_mod = mod; cfg_beg = beg; cfg_end = fin; cfg_inc = inc;
    cfg_dwl = dwl; cfg_rpt = rpt; cfg_inf = inf;
    ctl_str = 1'b1;
    @(negedge clk);
    ctl_str = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp += 5;
    if (stp_o !== '0)   begin n_err++; $display("FAIL reset stp_o: got %0d want 0", stp_o); end
    if (stp_upd !== 0)  begin n_err++; $display("FAIL reset stp_upd: got %0b want 0", stp_upd); end
    if (sts_run !== 0)  begin n_err++; $display("FAIL reset sts_run: got %0b want 0", sts_run); end
    if (sts_cnt !== '0) begin n_err++; $display("FAIL reset sts_cnt: got %0d want 0", sts_cnt); end
    if (irq_end !== 0)  begin n_err++; $display("FAIL reset irq_end: got %0b want 0", irq_end); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_up(input string tag);
    start(2'd0, 100, 130, 10, 3, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [CW-1:0] es;
      logic eu, ei, er;
      es = (i < 16) ? CW'(100 + 10 * (i / 4)) : CW'(130);
      eu = (i < 16) && (i % 4 == 0);
      ei = (i == 16);
      er = (i < 16);
      n_cmp += 4;
      if (stp_o !== es)   begin n_err++; $display("FAIL %s stp_o cyc %0d: got %0d want %0d", tag, i, stp_o, es); end
      if (stp_upd !== eu) begin n_err++; $display("FAIL %s stp_upd cyc %0d: got %0b want %0b", tag, i, stp_upd, eu); end
      if (irq_end !== ei) begin n_err++; $display("FAIL %s irq_end cyc %0d: got %0b want %0b", tag, i, irq_end, ei); end
      if (sts_run !== er) begin n_err++; $display("FAIL %s sts_run cyc %0d: got %0b want %0b", tag, i, sts_run, er); end
      @(negedge clk);
    end
  endtask

  task automatic test_clamp();
    logic [CW-1:0] ev[3][4];
    int ln[3];
    ev[0] = '{CW'(0), CW'(10), CW'(20), CW'(25)};
    ev[1] = '{CW'(25), CW'(15), CW'(5), CW'(0)};
    ev[2] = '{MAXV - CW'(4), MAXV, CW'(0), CW'(0)};
    ln = '{4, 4, 2};
    for (int s = 0; s < 3; s++) begin
      start(2'd0, ev[s][0], ev[s][ln[s]-1], 10, 0, 0, 1'b0);
      for (int i = 0; i <= ln[s]; i++) begin
        logic [CW-1:0] es;
        es = (i < ln[s]) ? ev[s][i] : ev[s][ln[s]-1];
        n_cmp += 2;
        if (stp_o !== es) begin n_err++; $display("FAIL clamp%0d stp_o cyc %0d: got %0d want %0d", s, i, stp_o, es); end
        if (irq_end !== (i == ln[s])) begin
          n_err++; $display("FAIL clamp%0d irq_end cyc %0d: got %0b want %0b", s, i, irq_end, (i == ln[s]));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_pingpong();
    logic [CW-1:0] ev[7];
    logic [NW-1:0] ec[7];
    int irqs;
    ev = '{CW'(0), CW'(10), CW'(20), CW'(10), CW'(0), CW'(10), CW'(20)};
    ec = '{NW'(0), NW'(0), NW'(0), NW'(1), NW'(1), NW'(2), NW'(2)};
    irqs = 0;
    start(2'd2, 0, 20, 10, 1, 2, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (irq_end === 1'b1) irqs++;
      if (i < 14) begin
        n_cmp += 3;
        if (stp_o !== ev[i/2])   begin n_err++; $display("FAIL pingpong stp_o cyc %0d: got %0d want %0d", i, stp_o, ev[i/2]); end
        if (sts_cnt !== ec[i/2]) begin n_err++; $display("FAIL pingpong sts_cnt cyc %0d: got %0d want %0d", i, sts_cnt, ec[i/2]); end
        if (stp_upd !== (i % 2 == 0)) begin
          n_err++; $display("FAIL pingpong stp_upd cyc %0d: got %0b want %0b", i, stp_upd, (i % 2 == 0));
        end
      end else if (i == 14) begin
        n_cmp += 3;
        if (irq_end !== 1'b1) begin n_err++; $display("FAIL pingpong irq_end: got %0b want 1", irq_end); end
        if (sts_cnt !== NW'(2)) begin n_err++; $display("FAIL pingpong final sts_cnt: got %0d want 2", sts_cnt); end
        if (sts_run !== 1'b0) begin n_err++; $display("FAIL pingpong sts_run end: got %0b want 0", sts_run); end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (irqs != 1) begin n_err++; $display("FAIL pingpong irq count: got %0d want 1", irqs); end
  endtask

  task automatic test_repeat_inf_stop();
    int irqs;
    int cnt_bad;
    irqs = 0;
    cnt_bad = 0;
    start(2'd1, 5, 7, 1, 0, 0, 1'b1);
    for (int i = 0; i < 100; i++) begin
      logic [CW-1:0] es;
      es = CW'(5 + i % 3);
      n_cmp++;
      if (stp_o !== es) begin n_err++; $display("FAIL repeat stp_o cyc %0d: got %0d want %0d", i, stp_o, es); end
      if (irq_end !== 1'b0) irqs++;
      if (sts_cnt !== '0) cnt_bad++;
      @(negedge clk);
    end
    n_cmp += 2;
    if (irqs != 0)    begin n_err++; $display("FAIL repeat irq count: got %0d want 0", irqs); end
    if (cnt_bad != 0) begin n_err++; $display("FAIL repeat sts_cnt nonzero cycles: got %0d want 0", cnt_bad); end
    ctl_stp = 1'b1;
    @(negedge clk);
    ctl_stp = 1'b0;
    n_cmp += 4;
    if (sts_run !== 1'b0) begin n_err++; $display("FAIL stop sts_run: got %0b want 0", sts_run); end
    if (stp_o !== CW'(6)) begin n_err++; $display("FAIL stop stp_o: got %0d want 6", stp_o); end
    if (stp_upd !== 1'b0) begin n_err++; $display("FAIL stop stp_upd: got %0b want 0", stp_upd); end
    if (irq_end !== 1'b0) begin n_err++; $display("FAIL stop irq_end: got %0b want 0", irq_end); end
    irqs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (irq_end !== 1'b0 || stp_o !== CW'(6)) irqs++;
    end
    n_cmp++;
    if (irqs != 0) begin n_err++; $display("FAIL stop hold: got %0d bad cycles want 0", irqs); end
  endtask

  task automatic test_start_stop_same();
    cfg_mod = 2'd0; cfg_beg = 77; cfg_end = 90; cfg_inc = 1; cfg_dwl = 0;
    ctl_str = 1'b1;
    ctl_stp = 1'b1;
    @(negedge clk);
    ctl_str = 1'b0;
    ctl_stp = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (sts_run !== 1'b0) begin n_err++; $display("FAIL strstp sts_run: got %0b want 0", sts_run); end
    if (stp_o !== CW'(6)) begin n_err++; $display("FAIL strstp stp_o: got %0d want 6", stp_o); end
    if (stp_upd !== 1'b0) begin n_err++; $display("FAIL strstp stp_upd: got %0b want 0", stp_upd); end
  endtask

  task automatic test_cfg_change();
    start(2'd0, 0, 30, 10, 1, 0, 1'b0);
    cfg_end = 100;
    cfg_beg = 50;
    cfg_inc = 1;
    for (int i = 0; i < 10; i++) begin
      logic [CW-1:0] es;
      es = (i < 8) ? CW'(10 * (i / 2)) : CW'(30);
      n_cmp += 2;
      if (stp_o !== es) begin n_err++; $display("FAIL cfgchg stp_o cyc %0d: got %0d want %0d", i, stp_o, es); end
      if (irq_end !== (i == 8)) begin n_err++; $display("FAIL cfgchg irq_end cyc %0d: got %0b want %0b", i, irq_end, (i == 8)); end
      ctl_str = (i == 3);
      @(negedge clk);
    end
    ctl_str = 1'b0;
  endtask

  task automatic test_inc_zero();
    start(2'd0, 3, 5, 0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [CW-1:0] es;
      es = (i < 3) ? CW'(3 + i) : CW'(5);
      n_cmp += 2;
      if (stp_o !== es) begin n_err++; $display("FAIL inc0 stp_o cyc %0d: got %0d want %0d", i, stp_o, es); end
      if (irq_end !== (i == 3)) begin n_err++; $display("FAIL inc0 irq_end cyc %0d: got %0b want %0b", i, irq_end, (i == 3)); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    start(2'd0, 100, 130, 10, 3, 0, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp += 4;
    if (stp_o !== '0)   begin n_err++; $display("FAIL arst stp_o: got %0d want 0", stp_o); end
    if (sts_run !== 0)  begin n_err++; $display("FAIL arst sts_run: got %0b want 0", sts_run); end
    if (sts_cnt !== '0) begin n_err++; $display("FAIL arst sts_cnt: got %0d want 0", sts_cnt); end
    if (irq_end !== 0)  begin n_err++; $display("FAIL arst irq_end: got %0b want 0", irq_end); end
    @(negedge clk);
    rst = 1'b0;
    test_single_up("restart");
  endtask

  initial begin
    test_reset();
    test_single_up("single");
    test_clamp();
    test_pingpong();
    test_repeat_inf_stop();
    test_start_stop_same();
    test_cfg_change();
    test_inc_zero();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
